writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
Final stage of the five-stage pipeline. It is the writer into the register-file write port that the decode stage reads from.
- Holds the MEM/WB pipeline register.
- Selects the write-back value from ALU result, memory data, input port or immediate, and drives reg_write/wd/wa to the register file.
- Exports the same write as a forwarding source.
- Keeps a retired-instruction counter for debug.

Parameters:
W, 16, datapath width
N, 3, register address width (2^N registers)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous reset, active-low (0 = reset)
in_valid  in  1  MEM stage presents a valid instruction
stall  in  1  hold MEM/WB register; suppress write and retire
flush  in  1  load a bubble into MEM/WB register
WB_signals_in  in  3  [2]=regWrite, [1:0]=WBsel
dst_in  in  N  destination register address
alu_res_in  in  W  ALU result from EX/MEM
mem_data_in  in  W  data-memory read data
imm_in  in  W  immediate carried down the pipe
in_port  in  W  external input port, sampled at load
reg_write  out  1  register-file write enable
wa  out  N  register-file write address
wd  out  W  register-file write data
fwd_valid  out  1  forwarding source valid (valid instr with regWrite=1)
retire_count  out  CNT_W  instructions retired since reset

Behaviour:
Internal state:
- wb_valid, wb_rw, wb_sel[1:0], wb_dst[N-1:0], wb_alu, wb_mem, wb_imm, wb_in (each W bits).
- retire counter.

Reset (rst=0, asynchronous, at any time, including mid-stall):
- All state cleared to 0.
- Outputs therefore: reg_write=0, wa=0, wd=0, fwd_valid=0, retire_count=0.
- Reset release takes effect at the first rising edge with rst=1.

Register update at each rising edge, priority order:
1. flush=1: wb_valid<=0, wb_rw<=0; data fields don't-care (implementation clears them to 0). The retire counter still updates per the rule below.
2. else stall=1: all MEM/WB fields hold.
3. else: wb_valid<=in_valid, wb_rw<=in_valid & WB_signals_in[2], wb_sel<=WB_signals_in[1:0], wb_dst<=dst_in, wb_alu<=alu_res_in, wb_mem<=mem_data_in, wb_imm<=imm_in, wb_in<=in_port.
- in_port is sampled only at load (case 3), so a later port change does not alter the written value.

Output logic (combinational from registered state only; latency 1 cycle from input edge to write):
- wd mux on wb_sel: 00=wb_alu, 01=wb_mem, 10=wb_in, 11=wb_imm.
- wa = wb_dst.
- fwd_valid = wb_valid & wb_rw. It is independent of stall, so a stalled producer still forwards.
- reg_write = wb_valid & wb_rw & ~stall. The write is asserted exactly once per instruction, in the cycle it leaves WB.

Retire counter:
- Increments by 1 at each rising edge where wb_valid=1 and stall=0, including when flush=1, because the outgoing instruction completes.
- Wraps from 2^CNT_W-1 to 0 silently.
- Bubbles never count.

Simultaneous events:
- flush with stall: flush wins; the register is bubbled. The held instruction is lost and not retired, since stall=1 blocks retire.
- in_valid=1 with regWrite=0 (store/branch): retires, never writes, fwd_valid=0.
- in_valid=0 with regWrite=1: treated as a bubble; no write.

No combinational path exists from any input to wd/wa/fwd_valid. stall reaches reg_write only through a single AND gate.

Test Plan:
- Reset mid-operation: load valid ALU write (dst=5, alu=0x1234), then assert rst=0 between edges → reg_write, wd, wa, fwd_valid, retire_count all 0 immediately, without waiting for a clock.
- WBsel sweep: back-to-back loads with alu=0x1111, mem=0x2222, in_port=0x3333, imm=0x4444, regWrite=1, dst=1..4, WBsel=00,01,10,11 → next four cycles reg_write=1, wa=1,2,3,4, wd=0x1111, 0x2222, 0x3333, 0x4444; retire_count reaches 4.
- Input-port sampling: load WBsel=10 with in_port=0xAAAA, then change in_port to 0x5555 during a 2-cycle stall → wd stays 0xAAAA; reg_write=0 during stall and 1 for one cycle after release; fwd_valid=1 throughout; retire increments once.
- Flush vs stall: hold valid instr (dst=7, wd=0x00FF) with stall=1, then assert stall=1 and flush=1 → next cycle wb_valid=0, reg_write=0, fwd_valid=0; retire_count unchanged.
- Non-writing instruction: in_valid=1, regWrite=0, dst=3 → reg_write=0, fwd_valid=0, retire_count +1. Then in_valid=0 with regWrite=1 → no write, no retire.
- Counter wrap (CNT_W=4): retire 17 valid instructions without stall → retire_count reads 15 after the 15th, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, write-back select, register-file
// write port, forwarding source and retired-instruction counter.
module writeback_stage #(
  parameter int W     = 16,
  parameter int N     = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [2:0]       WB_signals_in,
  input  logic [N-1:0]     dst_in,
  input  logic [W-1:0]     alu_res_in,
  input  logic [W-1:0]     mem_data_in,
  input  logic [W-1:0]     imm_in,
  input  logic [W-1:0]     in_port,
  output logic             reg_write,
  output logic [N-1:0]     wa,
  output logic [W-1:0]     wd,
  output logic             fwd_valid,
  output logic [CNT_W-1:0] retire_count
);

  logic         wb_valid;
  logic         wb_rw;
  logic [1:0]   wb_sel;
  logic [N-1:0] wb_dst;
  logic [W-1:0] wb_alu;
  logic [W-1:0] wb_mem;
  logic [W-1:0] wb_imm;
  logic [W-1:0] wb_in;
  logic [CNT_W-1:0] retire_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_rw    <= 1'b0;
      wb_sel   <= '0;
      wb_dst   <= '0;
      wb_alu   <= '0;
      wb_mem   <= '0;
      wb_imm   <= '0;
      wb_in    <= '0;
      retire_q <= '0;
    end else begin
      if (flush) begin
        wb_valid <= 1'b0;
        wb_rw    <= 1'b0;
        wb_sel   <= '0;
        wb_dst   <= '0;
        wb_alu   <= '0;
        wb_mem   <= '0;
        wb_imm   <= '0;
        wb_in    <= '0;
      end else if (!stall) begin
        wb_valid <= in_valid;
        wb_rw    <= in_valid & WB_signals_in[2];
        wb_sel   <= WB_signals_in[1:0];
        wb_dst   <= dst_in;
        wb_alu   <= alu_res_in;
        wb_mem   <= mem_data_in;
        wb_imm   <= imm_in;
        wb_in    <= in_port;
      end
      // The outgoing instruction completes even when a flush bubbles the register.
      if (wb_valid && !stall)
        retire_q <= retire_q + 1'b1;
    end
  end

  always_comb begin
    wd = wb_alu;
    unique case (wb_sel)
      2'b00: wd = wb_alu;
      2'b01: wd = wb_mem;
      2'b10: wd = wb_in;
      2'b11: wd = wb_imm;
      default: wd = wb_alu;
    endcase
  end

  assign wa           = wb_dst;
  assign fwd_valid    = wb_valid & wb_rw;
  assign reg_write    = fwd_valid & ~stall;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with an instruction-level reference model
// checked every cycle plus literal spot checks.
module tb_writeback_stage;

  localparam int W = 16;
  localparam int N = 3;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic [2:0]       WB_signals_in = '0;
  logic [N-1:0]     dst_in = '0;
  logic [W-1:0]     alu_res_in = '0;
  logic [W-1:0]     mem_data_in = '0;
  logic [W-1:0]     imm_in = '0;
  logic [W-1:0]     in_port = '0;
  logic             reg_write;
  logic [N-1:0]     wa;
  logic [W-1:0]     wd;
  logic             fwd_valid;
  logic [CNT_W-1:0] retire_count;

  int checks = 0;
  int errors = 0;

  writeback_stage #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .WB_signals_in(WB_signals_in), .dst_in(dst_in), .alu_res_in(alu_res_in),
    .mem_data_in(mem_data_in), .imm_in(imm_in), .in_port(in_port),
    .reg_write(reg_write), .wa(wa), .wd(wd), .fwd_valid(fwd_valid),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction sitting in WB, with its write value
  // resolved at the moment it is captured.
  bit          m_valid = 0;
  bit          m_rw = 0;
  int unsigned m_dst = 0;
  int unsigned m_val = 0;
  int unsigned m_ret = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid = 0; m_rw = 0; m_dst = 0; m_val = 0; m_ret = 0;
    end else begin
      if (m_valid && !stall) m_ret = (m_ret + 1) % (1 << CNT_W);
      if (flush) begin
        m_valid = 0; m_rw = 0; m_dst = 0; m_val = 0;
      end else if (!stall) begin
        m_valid = in_valid;
        m_rw    = in_valid && WB_signals_in[2];
        m_dst   = dst_in;
        case (WB_signals_in[1:0])
          2'd0: m_val = alu_res_in;
          2'd1: m_val = mem_data_in;
          2'd2: m_val = in_port;
          default: m_val = imm_in;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_reg_write", 32'(reg_write), 32'(m_valid && m_rw && !stall));
    chk("model_fwd_valid", 32'(fwd_valid), 32'(m_valid && m_rw));
    chk("model_wa", 32'(wa), m_dst);
    chk("model_wd", 32'(wd), m_val);
    chk("model_retire", 32'(retire_count), m_ret);
  end

  task automatic set_in(input bit v, input bit rw, input int unsigned sel, input int unsigned dst,
                        input int unsigned alu, input int unsigned mem, input int unsigned imm,
                        input int unsigned port, input bit stl, input bit fl);
    in_valid      = v;
    WB_signals_in = {rw, sel[1:0]};
    dst_in        = dst[N-1:0];
    alu_res_in    = alu[W-1:0];
    mem_data_in   = mem[W-1:0];
    imm_in        = imm[W-1:0];
    in_port       = port[W-1:0];
    stall         = stl;
    flush         = fl;
  endtask

  task automatic idle(input bit stl);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, stl, 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    chk("rst_reg_write", 32'(reg_write), 0);
    chk("rst_wd", 32'(wd), 0);
    chk("rst_wa", 32'(wa), 0);
    chk("rst_fwd", 32'(fwd_valid), 0);
    chk("rst_retire", 32'(retire_count), 0);
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    idle(0);
    cyc();
    cyc();
    chk("init_retire", 32'(retire_count), 0);
    chk("init_reg_write", 32'(reg_write), 0);
    rst = 1'b1;

    // Reset asserted between edges while a write is pending
    set_in(1, 1, 0, 5, 16'h1234, 0, 0, 0, 0, 0);
    cyc();
    idle(0);
    #1;
    chk("pre_rst_reg_write", 32'(reg_write), 1);
    chk("pre_rst_wd", 32'(wd), 32'h1234);
    chk("pre_rst_wa", 32'(wa), 5);
    reset_pulse();

    // WBsel sweep
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_in(1, 1, i, i + 1, 16'h1111, 16'h2222, 16'h4444, 16'h3333, 0, 0);
      else idle(0);
      #1;
      if (i > 0) begin
        chk("sweep_reg_write", 32'(reg_write), 1);
        chk("sweep_wa", 32'(wa), i);
        chk("sweep_wd", 32'(wd), 32'h1111 * i);
        chk("sweep_retire", 32'(retire_count), i - 1);
      end
      cyc();
    end
    chk("sweep_retire_final", 32'(retire_count), 4);

    // in_port sampled at load, stable through a stall
    set_in(1, 1, 2, 6, 0, 0, 0, 16'hAAAA, 0, 0);
    cyc();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 16'h5555, 1, 0);
      #1;
      chk("port_stall_reg_write", 32'(reg_write), 0);
      chk("port_stall_fwd", 32'(fwd_valid), 1);
      chk("port_stall_wd", 32'(wd), 32'hAAAA);
      cyc();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 16'h5555, 0, 0);
    #1;
    chk("port_release_reg_write", 32'(reg_write), 1);
    chk("port_release_wd", 32'(wd), 32'hAAAA);
    chk("port_release_retire", 32'(retire_count), 4);
    cyc();
    chk("port_after_retire", 32'(retire_count), 5);
    chk("port_after_fwd", 32'(fwd_valid), 0);

    // Flush beats stall: held instruction is dropped without retiring
    set_in(1, 1, 0, 7, 16'h00FF, 0, 0, 0, 0, 0);
    cyc();
    idle(1);
    #1;
    chk("hold_wd", 32'(wd), 32'h00FF);
    chk("hold_reg_write", 32'(reg_write), 0);
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc();
    idle(0);
    #1;
    chk("flush_reg_write", 32'(reg_write), 0);
    chk("flush_fwd", 32'(fwd_valid), 0);
    chk("flush_retire", 32'(retire_count), 5);
    cyc();
    chk("flush_retire_after", 32'(retire_count), 5);

    // Non-writing instruction, then regWrite on a bubble
    set_in(1, 0, 0, 3, 16'h0009, 0, 0, 0, 0, 0);
    cyc();
    set_in(0, 1, 0, 2, 16'h0009, 0, 0, 0, 0, 0);
    #1;
    chk("store_reg_write", 32'(reg_write), 0);
    chk("store_fwd", 32'(fwd_valid), 0);
    chk("store_wa", 32'(wa), 3);
    cyc();
    idle(0);
    #1;
    chk("store_retire", 32'(retire_count), 6);
    chk("bubble_reg_write", 32'(reg_write), 0);
    cyc();
    chk("bubble_retire", 32'(retire_count), 6);

    // Flush of a valid, unstalled instruction still retires it
    set_in(1, 1, 3, 4, 0, 0, 16'h0BEE, 0, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("flush_go_reg_write", 32'(reg_write), 1);
    chk("flush_go_wd", 32'(wd), 32'h0BEE);
    cyc();
    idle(0);
    chk("flush_go_retire", 32'(retire_count), 7);

    // Counter wrap at CNT_W=4
    reset_pulse();
    for (int i = 0; i < 19; i++) begin
      if (i < 17) set_in(1, 1, 0, i % 8, i, 0, 0, 0, 0, 0);
      else idle(0);
      #1;
      if (i == 16) chk("wrap_15", 32'(retire_count), 15);
      if (i == 17) chk("wrap_0", 32'(retire_count), 0);
      if (i == 18) chk("wrap_1", 32'(retire_count), 1);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
